// File: rtl/bit_test_unit_if.sv
// ============================================================================
// Module   : bit_test_unit_if
// Purpose  : Start/busy/done handshake and operand bus for the bit test unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface bit_test_unit_if #(
    parameter int WIDTH = 16,
    parameter int SEL_W = 4
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [SEL_W-1:0] bs;
    logic             busy;
    logic             done;
    logic             f;
    logic [WIDTH-1:0] result;
    logic [SEL_W-1:0] index;
    logic             err;

    modport master (
        output start, op, a, bs,
        input  busy, done, f, result, index, err
    );

    modport slave (
        input  start, op, a, bs,
        output busy, done, f, result, index, err
    );
endinterface

`default_nettype wire

// File: rtl/bit_test_unit.sv
// ============================================================================
// Module   : bit_test_unit
// Purpose  : Registered TEST/SET/CLR/TGL on one bit plus multi-cycle scans
//            for the first set bit upward or downward from a start position.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bit_test_unit #(
    parameter int WIDTH = 16,
    parameter int SEL_W = 4
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    bit_test_unit_if.slave   bus
);
    localparam logic [2:0]       C_OP_SET     = 3'b001;
    localparam logic [2:0]       C_OP_CLR     = 3'b010;
    localparam logic [2:0]       C_OP_TGL     = 3'b011;
    localparam logic [2:0]       C_OP_SCAN_UP = 3'b100;
    localparam logic [SEL_W:0]   C_WIDTH_EXT  = (SEL_W+1)'(WIDTH);
    localparam logic [SEL_W-1:0] C_LAST       = SEL_W'(WIDTH-1);
    localparam logic [WIDTH-1:0] C_ONE        = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [SEL_W-1:0] r_ptr;
    logic             r_up;
    logic             r_busy;
    logic             r_done;
    logic             r_f;
    logic [WIDTH-1:0] r_result;
    logic [SEL_W-1:0] r_index;
    logic             r_err;

    logic             w_oor;
    logic             w_illegal;
    logic [WIDTH-1:0] w_in_mask;
    logic             w_in_bit;
    logic [WIDTH-1:0] w_modified;
    logic [WIDTH-1:0] w_scan_mask;
    logic             w_scan_bit;
    logic             w_terminal;

    // Select is widened by one bit so WIDTH == 2**SEL_W compares correctly.
    assign w_oor       = {1'b0, bus.bs} >= C_WIDTH_EXT;
    assign w_illegal   = bus.op[2] & bus.op[1];
    assign w_in_mask   = C_ONE << bus.bs;
    assign w_in_bit    = |(bus.a & w_in_mask);
    assign w_scan_mask = C_ONE << r_ptr;
    assign w_scan_bit  = |(r_a & w_scan_mask);
    assign w_terminal  = r_up ? (r_ptr == C_LAST) : (r_ptr == '0);

    always_comb begin
        w_modified = bus.a;
        case (bus.op)
            C_OP_SET: w_modified = bus.a | w_in_mask;
            C_OP_CLR: w_modified = bus.a & ~w_in_mask;
            C_OP_TGL: w_modified = bus.a ^ w_in_mask;
            default:  w_modified = bus.a;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_ptr    <= '0;
            r_up     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_f      <= 1'b0;
            r_result <= '0;
            r_index  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a   <= bus.a;
                        r_ptr <= bus.bs;
                        r_up  <= (bus.op == C_OP_SCAN_UP);
                        if (w_illegal || w_oor) begin
                            r_done   <= 1'b1;
                            r_err    <= 1'b1;
                            r_f      <= 1'b0;
                            r_result <= bus.a;
                            r_index  <= bus.bs;
                        end else if (bus.op[2]) begin
                            r_state <= S_SCAN;
                            r_busy  <= 1'b1;
                        end else begin
                            r_done   <= 1'b1;
                            r_err    <= 1'b0;
                            r_f      <= w_in_bit;
                            r_result <= w_modified;
                            r_index  <= bus.bs;
                        end
                    end
                end
                S_SCAN: begin
                    // Terminal test precedes the step, so ptr never wraps.
                    if (w_scan_bit || w_terminal) begin
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_err    <= 1'b0;
                        r_f      <= w_scan_bit;
                        r_result <= r_a;
                        r_index  <= r_ptr;
                    end else if (r_up) begin
                        r_ptr <= r_ptr + 1'b1;
                    end else begin
                        r_ptr <= r_ptr - 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.f      = r_f;
    assign bus.result = r_result;
    assign bus.index  = r_index;
    assign bus.err    = r_err;
endmodule

`default_nettype wire

// File: tb/tb_bit_test_unit.sv
// ============================================================================
// Module   : tb_bit_test_unit
// Purpose  : Randomised and directed scoreboard bench for bit_test_unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bit_test_unit;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;

    bit_test_unit_if #(.WIDTH(W), .SEL_W(4)) bus ();
    bit_test_unit_if #(.WIDTH(12), .SEL_W(4)) bus12 ();

    bit_test_unit #(.WIDTH(W), .SEL_W(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    bit_test_unit #(.WIDTH(12), .SEL_W(4)) dut12 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus12.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    typedef struct {
        int          issue_cyc;
        int          done_cyc;
        bit          scan;
        logic        f;
        logic [15:0] res;
        logic [3:0]  idx;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [21:0] last = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: direct reading of the operation rules, searching bit by bit.
    function automatic exp_t model(input logic [2:0] op, input logic [15:0] a,
                                   input logic [3:0] bs, input int c);
        exp_t e;
        int   p;
        int   n;
        e.issue_cyc = c;
        e.done_cyc  = c + 1;
        e.scan      = 0;
        e.f         = 0;
        e.res       = a;
        e.idx       = bs;
        e.err       = 0;
        if (op >= 3'd6 || int'(bs) >= W) begin
            e.err = 1;
        end else if (op < 3'd4) begin
            e.f = a[bs];
            if (op == 3'd1) e.res[bs] = 1'b1;
            if (op == 3'd2) e.res[bs] = 1'b0;
            if (op == 3'd3) e.res[bs] = ~a[bs];
        end else begin
            e.scan = 1;
            p = int'(bs);
            n = 0;
            while (a[p] == 1'b0 && p != ((op == 3'd4) ? W - 1 : 0)) begin
                p = (op == 3'd4) ? p + 1 : p - 1;
                n++;
            end
            e.f        = a[p];
            e.idx      = 4'(p);
            e.done_cyc = c + n + 2;
        end
        return e;
    endfunction

    // Monitor: busy window, done timing and values, output hold between dones.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                bit   exp_busy;
                exp_t e;
                exp_busy = 0;
                if (sb.size() > 0 && sb[0].scan && cyc > sb[0].issue_cyc && cyc < sb[0].done_cyc)
                    exp_busy = 1;
                chk("busy", 64'(bus.busy), 64'(exp_busy));
                if (sb.size() > 0 && sb[0].done_cyc < cyc) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL done_timeout: no done by cycle %0d expected at %0d", cyc, sb[0].done_cyc);
                    void'(sb.pop_front());
                end
                if (bus.done === 1'b1) begin
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_done: got done=1 expected none at cycle %0d", cyc);
                    end else begin
                        e = sb.pop_front();
                        chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
                        chk("f",      64'(bus.f),      64'(e.f));
                        chk("result", 64'(bus.result), 64'(e.res));
                        chk("index",  64'(bus.index),  64'(e.idx));
                        chk("err",    64'(bus.err),    64'(e.err));
                        last = {e.f, e.res, e.idx, e.err};
                    end
                end else begin
                    chk("hold", 64'({bus.f, bus.result, bus.index, bus.err}), 64'(last));
                end
            end
        end
    end

    // Called right after a falling edge; returns positioned on the next
    // falling edge where a new op may be issued.
    task automatic issue(input logic [2:0] op, input logic [15:0] a,
                         input logic [3:0] bs, input int inj);
        exp_t e;
        e = model(op, a, bs, cyc);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.bs    = bs;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        if (e.scan) begin
            for (int k = 0; k < 40; k++) begin
                bus.start = 1'b0;
                bus.a     = 16'($urandom);
                bus.bs    = 4'($urandom);
                if (bus.busy !== 1'b1) break;
                if (k == inj) begin
                    bus.start = 1'b1;
                    bus.op    = 3'($urandom_range(0, 5));
                end
                @(negedge clk);
            end
        end
    endtask

    initial begin
        exp_t er;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.op      = '0;
        bus.a       = '0;
        bus.bs      = '0;
        bus12.start = 1'b0;
        bus12.op    = '0;
        bus12.a     = '0;
        bus12.bs    = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy",   64'(bus.busy),   64'(0));
        chk("rst_done",   64'(bus.done),   64'(0));
        chk("rst_f",      64'(bus.f),      64'(0));
        chk("rst_result", 64'(bus.result), 64'(0));
        chk("rst_index",  64'(bus.index),  64'(0));
        chk("rst_err",    64'(bus.err),    64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        for (int b = 0; b < 16; b++) issue(3'd0, 16'hA5C3, 4'(b), -1);
        issue(3'd1, 16'h00F0, 4'd4, -1);
        issue(3'd2, 16'h00F0, 4'd4, -1);
        issue(3'd3, 16'h00F0, 4'd0, -1);
        issue(3'd4, 16'h0100, 4'd3, 2);
        issue(3'd4, 16'h0000, 4'd0, 7);
        issue(3'd5, 16'h0009, 4'd12, 3);
        issue(3'd5, 16'h0000, 4'd15, -1);
        issue(3'd6, 16'h1234, 4'd5, -1);
        issue(3'd7, 16'hBEEF, 4'd15, -1);
        issue(3'd4, 16'h8000, 4'd15, -1);
        issue(3'd0, 16'h5A5A, 4'd1, -1);

        for (int i = 0; i < 150; i++)
            issue(3'($urandom_range(0, 7)), 16'($urandom), 4'($urandom), $urandom_range(0, 6));

        // Narrow instance: select beyond WIDTH must be rejected in one cycle.
        bus12.start = 1'b1;
        bus12.op    = 3'd1;
        bus12.a     = 12'hABC;
        bus12.bs    = 4'd13;
        @(negedge clk);
        bus12.start = 1'b1;
        bus12.op    = 3'd4;
        bus12.a     = 12'h001;
        bus12.bs    = 4'd12;
        chk("w12_done",   64'(bus12.done),   64'(1));
        chk("w12_err",    64'(bus12.err),    64'(1));
        chk("w12_f",      64'(bus12.f),      64'(0));
        chk("w12_result", 64'(bus12.result), 64'(12'hABC));
        chk("w12_index",  64'(bus12.index),  64'(13));
        @(negedge clk);
        bus12.start = 1'b0;
        chk("w12_scan_oor_done", 64'(bus12.done), 64'(1));
        chk("w12_scan_oor_err",  64'(bus12.err),  64'(1));
        chk("w12_scan_oor_busy", 64'(bus12.busy), 64'(0));

        // Abort a long scan with an asynchronous reset pulse.
        er = model(3'd4, 16'h8000, 4'd0, cyc);
        bus.start = 1'b1;
        bus.op    = 3'd4;
        bus.a     = 16'h8000;
        bus.bs    = 4'd0;
        sb.push_back(er);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        sb.delete();
        last = '0;
        #1;
        chk("abort_busy",   64'(bus.busy),   64'(0));
        chk("abort_done",   64'(bus.done),   64'(0));
        chk("abort_f",      64'(bus.f),      64'(0));
        chk("abort_result", 64'(bus.result), 64'(0));
        chk("abort_index",  64'(bus.index),  64'(0));
        chk("abort_err",    64'(bus.err),    64'(0));
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        repeat (20) @(negedge clk);
        issue(3'd0, 16'h0004, 4'd2, -1);

        repeat (25) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d outstanding expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/bit_test_unit.md
Name: bit_test_unit

Overview:
Parametrised, registered successor to the 16-bit combinational bit tester in the processor datapath. It supports TEST/SET/CLEAR/TOGGLE on a selected bit with single-cycle latency. It also provides multi-cycle SCAN_UP/SCAN_DOWN operations, which locate the first set bit from a start position for the control unit's bit-search instructions. It uses a start/busy/done handshake and sits beside the ALU on the A operand bus.

Parameters:
WIDTH, 16, operand width in bits (2..64).
SEL_W, 4, bit-select width; requires 2**SEL_W >= WIDTH.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  operation request; sampled only when busy=0.
op  input  3  000 TEST, 001 SET, 010 CLR, 011 TGL, 100 SCAN_UP, 101 SCAN_DN, 11x illegal.
a  input  WIDTH  operand; captured when start is accepted.
bs  input  SEL_W  bit select / scan start position; captured with a.
busy  output  1  high while a scan is in progress.
done  output  1  one-cycle pulse when outputs are updated.
f  output  1  tested bit (TEST/SET/CLR/TGL) or found flag (SCAN).
result  output  WIDTH  modified operand (SET/CLR/TGL); captured a otherwise.
index  output  SEL_W  scan hit position, or last position examined.
err  output  1  high for an illegal op or bs >= WIDTH; valid with done.

Behaviour:
- Reset (async, rst_n=0): FSM goes to IDLE. busy, done, f, err = 0; result = 0; index = 0; internal capture registers = 0.
- FSM states are IDLE and SCAN. done is a registered pulse, never combinational from start.
- Acceptance: start=1 in IDLE is sampled on the clock edge; a, bs and op are latched on that edge.
- TEST/SET/CLR/TGL (single-cycle ops):
  - Latency 1: done=1 in the cycle after the accepting edge; FSM stays in IDLE and busy stays 0.
  - f = a[bs] before modification.
  - result = a with bit bs forced 1 (SET), forced 0 (CLR) or inverted (TGL); result = a for TEST.
  - index = bs; err = 0.
- Out-of-range select (bs >= WIDTH) on any op: done after 1 cycle with err=1, f=0, result=a, index=bs. No scan is started.
- Illegal op (11x): done after 1 cycle with err=1, f=0, result=a, index=bs.
- SCAN_UP / SCAN_DN:
  - On acceptance, FSM enters SCAN with busy=1 and pointer ptr=bs.
  - Each SCAN cycle examines captured a[ptr]:
    - Bit is 1: hit. f=1, index=ptr.
    - Bit is 0 and ptr is the terminal position (WIDTH-1 for UP, 0 for DN): f=0, index=terminal.
    - Otherwise: ptr increments (UP) or decrements (DN). No wrap-around.
  - On hit or terminal, outputs register at the end of that cycle and done=1 in the next cycle. busy drops in the same cycle done rises; FSM returns to IDLE.
  - Latency: a hit at distance n from bs gives done n+2 cycles after the start cycle (start cycle = cycle 0).
  - Maximum latency is WIDTH+1 cycles.
  - result = captured a; err = 0.
- start while busy=1 is ignored; no queueing.
- start in the same cycle done=1: accepted, since the FSM is in IDLE; back-to-back single-cycle ops give one done per cycle.
- Output hold: f, result, index and err hold their values between done pulses. Changes on a or bs after acceptance have no effect.
- Reset mid-scan: immediate abort to the reset state; no done pulse is generated.
- Index arithmetic: ptr is SEL_W bits, compared against WIDTH-1 and 0 explicitly. No overflow occurs because the terminal position is checked before increment or decrement.

Test Plan:
- TEST sweep, WIDTH=16, a=16'hA5C3, bs=0..15 back-to-back: done every cycle, f matches a[bs] (bs=0 -> 1, bs=2 -> 0, bs=15 -> 1), busy never 1.
- SET/CLR/TGL, a=16'h00F0, bs=4: SET -> result=16'h00F0, f=1. CLR -> result=16'h00E0, f=1. TGL bs=0 -> result=16'h00F1, f=0.
- SCAN_UP, a=16'h0100, bs=3: busy for 6 cycles, done in cycle 7, f=1, index=8. With a=16'h0000, bs=0: done in cycle 17, f=0, index=15.
- SCAN_DN, a=16'h0009, bs=12: index=3, f=1, done in cycle 11. start pulsed mid-scan is ignored: no extra done, outputs unchanged.
- Errors: op=3'b110 -> err=1, f=0, result=a. Parametrised WIDTH=12, bs=13, op=SET -> err=1, result=a, done after 1 cycle.
- Reset: rst_n=0 for 1 cycle during a SCAN_UP on a=16'h8000, bs=0 -> busy=0 and all outputs 0 asynchronously, no done. A new TEST after release gives correct f.
